// File: rtl/icache_controller.sv
// Direct-mapped 8x16B instruction cache; hits return same cycle, misses stall via BUSYWAIT for N+3 cycles.
// Backpressure: the memory holds a fill with MEM_BUSYWAIT; the CPU is held with BUSYWAIT.
module icache_controller (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEM_READ = 2'd1;
  localparam logic [1:0] ST_UPDATE   = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [5:0]   fill_addr_q, fill_addr_d;
  logic [7:0]   valid_q;
  logic [2:0]   tag_q  [8];
  logic [127:0] data_q [8];

  logic [2:0] pc_tag;
  logic [2:0] pc_index;
  logic [1:0] pc_word;
  logic       hit;
  logic       fill_we;
  logic       unused_pc;

  assign pc_tag    = PC[9:7];
  assign pc_index  = PC[6:4];
  assign pc_word   = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  assign hit         = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign INSTRUCTION = hit ? data_q[pc_index][pc_word*32 +: 32] : 32'h0;

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hit) begin
          fill_addr_d = PC[9:4];
          state_d     = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (!MEM_BUSYWAIT) begin
          fill_we = 1'b1;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Reset overrides everything, including a data return on the same edge.
    if (!RESET) begin
      state_d     = ST_IDLE;
      fill_addr_d = 6'd0;
      fill_we     = 1'b0;
    end
  end

  always_comb begin
    BUSYWAIT    = 1'b1;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = fill_addr_q;
    case (state_q)
      ST_IDLE:     BUSYWAIT = !hit;
      ST_MEM_READ: MEM_READ = 1'b1;
      default:     BUSYWAIT = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    state_q     <= state_d;
    fill_addr_q <= fill_addr_d;
    if (!RESET) begin
      valid_q <= 8'h00;
    end else if (fill_we) begin
      valid_q[fill_addr_q[2:0]] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_addr_q[2:0]]  <= fill_addr_q[5:3];
      data_q[fill_addr_q[2:0]] <= MEM_READDATA;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: behavioural block memory with programmable latency and an instruction scoreboard.
module tb_icache_controller;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_vec = 0;
  int n_err = 0;
  int mem_n = 0;
  int mem_cnt = 0;
  logic [31:0] sb_q[$];

  always #5 CLK = ~CLK;

  icache_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  // Word w of memory block a; distinct per block and per word.
  function automatic logic [31:0] mw(input logic [5:0] a, input logic [1:0] w);
    return {8'hC3, 2'b00, a, 6'h00, w, 8'h5A};
  endfunction

  // Memory busies for mem_n cycles after MEM_READ rises, then returns data for one cycle.
  always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_n);
  assign MEM_READDATA = (MEM_READ && !MEM_BUSYWAIT) ?
                        {mw(MEM_ADDRESS, 2'd3), mw(MEM_ADDRESS, 2'd2),
                         mw(MEM_ADDRESS, 2'd1), mw(MEM_ADDRESS, 2'd0)} : 128'h0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_bw"},   {31'd0, BUSYWAIT}, 32'd1);
    chk({tag, "_rd"},   {31'd0, MEM_READ}, 32'd0);
    chk({tag, "_addr"}, {26'd0, MEM_ADDRESS}, 32'd0);
    chk({tag, "_ins"},  INSTRUCTION, 32'd0);
  endtask

  // Drive a fetch, expect a miss (N+3 stall cycles) or a hit (none), then check the returned word.
  task automatic fetch(input string tag, input logic [31:0] pc, input int n, input bit miss);
    int stall;
    int rd_cycles;
    bit addr_ok;
    logic [5:0] exp_addr;
    logic [31:0] got;
    mem_n = n;
    PC = pc;
    exp_addr = pc[9:4];
    sb_q.push_back(mw(pc[9:4], pc[3:2]));
    #1;
    stall = 0;
    rd_cycles = 0;
    addr_ok = 1'b1;
    while (BUSYWAIT === 1'b1 && stall < 100) begin
      stall++;
      if (MEM_READ === 1'b1) begin
        rd_cycles++;
        if (MEM_ADDRESS !== exp_addr) addr_ok = 1'b0;
      end
      tick();
    end
    chk({tag, "_stall"}, stall, miss ? n + 3 : 0);
    if (miss) begin
      chk({tag, "_rdcyc"}, rd_cycles, n + 1);
      chk({tag, "_addr"}, {31'd0, addr_ok}, 32'd1);
    end
    chk({tag, "_rd_after"}, {31'd0, MEM_READ}, 32'd0);
    got = sb_q.pop_front();
    chk({tag, "_ins"}, INSTRUCTION, got);
    tick();
  endtask

  initial begin
    RESET = 1'b0;
    PC = 32'h0;
    tick();
    tick();
    chk_idle_reset("rst_hold");
    RESET = 1'b1;

    fetch("fill0_w0", 32'h000, 5, 1'b1);
    fetch("hit_w1",   32'h004, 5, 1'b0);
    fetch("hit_w2",   32'h008, 5, 1'b0);
    fetch("hit_w3",   32'h00C, 5, 1'b0);
    fetch("alias",    32'h400, 5, 1'b0);
    fetch("conflict", 32'h080, 2, 1'b1);
    fetch("hit_b1",   32'h084, 2, 1'b0);
    fetch("refill0",  32'h000, 2, 1'b1);

    // Reset during the third MEM_READ cycle of a slow fill.
    mem_n = 10;
    PC = 32'h020;
    tick();
    chk("midfill_rd1", {31'd0, MEM_READ}, 32'd1);
    chk("midfill_ad1", {26'd0, MEM_ADDRESS}, 32'h02);
    tick();
    tick();
    chk("midfill_rd3", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b0;
    tick();
    chk_idle_reset("midfill_rst");
    tick();
    chk_idle_reset("midfill_hold");
    RESET = 1'b1;
    #1;
    chk("midfill_miss", {31'd0, BUSYWAIT}, 32'd1);
    fetch("post_rst0", 32'h000, 2, 1'b1);

    // Reset lands on the very edge the memory returns data.
    mem_n = 3;
    PC = 32'h030;
    tick();
    tick();
    tick();
    tick();
    chk("ret_rd", {31'd0, MEM_READ}, 32'd1);
    chk("ret_bw", {31'd0, MEM_BUSYWAIT}, 32'd0);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    #1;
    chk("ret_not_inst", {31'd0, BUSYWAIT}, 32'd1);
    chk("ret_ins0", INSTRUCTION, 32'd0);
    fetch("post_ret", 32'h030, 1, 1'b1);

    fetch("n0_miss", 32'h050, 0, 1'b1);
    fetch("n0_miss2", 32'h1D8, 0, 1'b1);
    fetch("n0_hit", 32'h1D4, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
